// File: rtl/is_jump_instruction.sv
// Jump-class decoder for the 8-bit instruction set: combinational jump flag plus a
// registered, valid-qualified flag/target. Optional saturating jump counter under JUMP_COUNT_EN.
module is_jump_instruction #(
  parameter logic [1:0]  JUMP_OPCODE = 2'b11,
  parameter int unsigned TARGET_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          instruction,
  input  logic                instr_valid,
  output logic                jump,
  output logic                jump_q,
  output logic [TARGET_W-1:0] target_q,
  output logic                out_valid
`ifdef JUMP_COUNT_EN
  ,
  output logic [15:0]         jump_count
`endif
);

  logic                w_jump;
  logic                w_capture;
  logic                r_jump_q;
  logic [TARGET_W-1:0] r_target_q;
  logic                r_out_valid;

  // Only the opcode field takes part, so unknown target bits cannot reach the flag.
  always_comb begin
    w_jump    = 1'b0;
    w_capture = 1'b0;
    if (instruction[7:6] == JUMP_OPCODE) begin
      w_jump = 1'b1;
    end else begin
      w_jump = 1'b0;
    end
    w_capture = instr_valid & w_jump;
  end

  assign jump = w_jump;

  // Pipeline register: target only moves on a valid jump, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump_q    <= 1'b0;
      r_target_q  <= {TARGET_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_jump_q    <= w_capture;
      r_out_valid <= instr_valid;
      if (w_capture) begin
        r_target_q <= instruction[TARGET_W-1:0];
      end else begin
        r_target_q <= r_target_q;
      end
    end
  end

  assign jump_q    = r_jump_q;
  assign target_q  = r_target_q;
  assign out_valid = r_out_valid;

`ifdef JUMP_COUNT_EN
  logic [15:0] r_jump_count;

  // Saturating count of registered jumps; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump_count <= 16'h0000;
    end else if (w_capture && (r_jump_count != 16'hFFFF)) begin
      r_jump_count <= r_jump_count + 16'd1;
    end else begin
      r_jump_count <= r_jump_count;
    end
  end

  assign jump_count = r_jump_count;
`endif

endmodule

// File: tb/tb_is_jump_instruction.sv
// Directed table-driven bench for is_jump_instruction, with hand sequences for
// reset behaviour and (when JUMP_COUNT_EN is defined) the saturating counter.
module tb_is_jump_instruction;

  logic       clk;
  logic       rst_n;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       jump;
  logic       jump_q;
  logic [5:0] target_q;
  logic       out_valid;
`ifdef JUMP_COUNT_EN
  logic [15:0] jump_count;
`endif

  int n_pass;
  int n_total;

  typedef struct {
    logic [7:0] instr;
    logic       valid;
    logic       exp_jump;
    logic       exp_jump_q;
    logic [5:0] exp_target;
    logic       exp_out_valid;
  } vec_t;

  vec_t vecs[11];

  is_jump_instruction dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .jump        (jump),
    .jump_q      (jump_q),
    .target_q    (target_q),
    .out_valid   (out_valid)
`ifdef JUMP_COUNT_EN
    ,
    .jump_count  (jump_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_regs(input string tag, input logic jq, input logic [5:0] tq, input logic ov);
    chk({tag, " jump_q"},    {15'd0, jump_q},    {15'd0, jq});
    chk({tag, " target_q"},  {10'd0, target_q},  {10'd0, tq});
    chk({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, ov});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[1]  = '{8'hC0, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1};
    vecs[2]  = '{8'h80, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1};
    vecs[3]  = '{8'hC5, 1'b1, 1'b1, 1'b1, 6'h05, 1'b1};
    vecs[4]  = '{8'h40, 1'b1, 1'b0, 1'b0, 6'h05, 1'b1};
    vecs[5]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 6'h05, 1'b0};
    vecs[6]  = '{8'hFA, 1'b1, 1'b1, 1'b1, 6'h3A, 1'b1};
    vecs[7]  = '{8'h3F, 1'b1, 1'b0, 1'b0, 6'h3A, 1'b1};
    vecs[8]  = '{8'hE1, 1'b1, 1'b1, 1'b1, 6'h21, 1'b1};
    vecs[9]  = '{8'hDE, 1'b1, 1'b1, 1'b1, 6'h1E, 1'b1};
    vecs[10] = '{8'hBF, 1'b0, 1'b0, 1'b0, 6'h1E, 1'b0};

    rst_n       = 1'b0;
    instruction = 8'h00;
    instr_valid = 1'b0;
    #12;
    chk_regs("reset", 1'b0, 6'h00, 1'b0);
    chk("reset jump", {15'd0, jump}, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_regs("post-deassert hold", 1'b0, 6'h00, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      instruction = vecs[i].instr;
      instr_valid = vecs[i].valid;
      #1;
      chk($sformatf("v%0d jump", i), {15'd0, jump}, {15'd0, vecs[i].exp_jump});
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), vecs[i].exp_jump_q, vecs[i].exp_target, vecs[i].exp_out_valid);
    end

    // Unknown target bits must not disturb the combinational flag.
    @(negedge clk);
    instruction = {2'b11, 6'bxxxxxx};
    instr_valid = 1'b0;
    #1;
    chk("x-bits jump", {15'd0, jump}, 16'd1);

    // Mid-stream asynchronous reset.
    @(negedge clk);
    instruction = 8'hC7;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("stream", 1'b1, 6'h07, 1'b1);
    #2;
    rst_n       = 1'b0;
    instruction = 8'hC1;
    #1;
    chk_regs("async reset", 1'b0, 6'h00, 1'b0);
    chk("jump during reset", {15'd0, jump}, 16'd1);
    @(posedge clk);
    #1;
    chk_regs("reset held over edge", 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    rst_n       = 1'b1;
    instruction = 8'h00;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_regs("after reset idle", 1'b0, 6'h00, 1'b0);

`ifdef JUMP_COUNT_EN
    chk("count after reset", jump_count, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instruction = 8'hC0 | 8'(k);
      instr_valid = 1'b1;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("count three", jump_count, 16'h0003);
    instr_valid = 1'b1;
    instruction = 8'hC9;
    for (int k = 0; k < 65532; k++) @(negedge clk);
    chk("count saturate", jump_count, 16'hFFFF);
    @(negedge clk);
    chk("count hold sat", jump_count, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("count async reset", jump_count, 16'h0000);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
